// File: rtl/mem_access_unit.sv
// Purpose : MEM-stage responder; runs lw/sw/sh against a handshaked data memory and stalls the pipe meanwhile.
// Latency : 2 stall cycles for an access acked in its first REQ cycle, +1 per ack wait; errors stall 1 cycle.
// Backpressure: stall is held while the access is pending; m_ack completes it, TIMEOUT aborts it.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   ctrl_mem[2:0]       {MEM_RD, MEM_WR, w_h}; RD/WR are active-low, w_h=1 word / 0 halfword
//   addr, wdata         byte address and store data from EX/MEM
//   stall               freeze IF..EX/MEM (combinational)
//   rdata, rdata_valid  load result and its one-cycle update pulse
//   err                 one-cycle pulse on misaligned, illegal or timed-out access
//   m_req/m_we/m_addr/m_be/m_wdata  registered memory request
//   m_ack, m_rdata      memory completion and read data
module mem_access_unit #(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        ctrl_mem,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic [31:0]       rdata,
    output logic              rdata_valid,
    output logic              err,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [3:0]        m_be,
    output logic [31:0]       m_wdata,
    input  logic              m_ack,
    input  logic [31:0]       m_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [7:0] TO_CNT = TIMEOUT[7:0];

    state_t            state, state_nxt;
    logic [7:0]        cnt, cnt_nxt;
    logic [7:0]        cnt_inc;
    logic              m_req_nxt, m_we_nxt;
    logic [ADDR_W-1:0] m_addr_nxt;
    logic [3:0]        m_be_nxt;
    logic [31:0]       m_wdata_nxt;
    logic [31:0]       rdata_nxt;
    logic              rdata_valid_nxt, err_nxt;

    logic              mem_rd, mem_wr, w_h;
    logic              access;

    // Byte-address bits above the word-address window are not used by the memory.
    logic              unused_addr_hi;
    assign unused_addr_hi = ^addr[31:ADDR_W+2];

    assign mem_rd  = ~ctrl_mem[2];
    assign mem_wr  = ~ctrl_mem[1];
    assign w_h     = ctrl_mem[0];
    assign access  = mem_rd | mem_wr;
    assign cnt_inc = cnt + 8'd1;

    // Gated by rst_n so every output reads 0 while reset is asserted.
    assign stall = rst_n & (((state == S_IDLE) & access) | (state == S_REQ));

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        m_req_nxt       = m_req;
        m_we_nxt        = m_we;
        m_addr_nxt      = m_addr;
        m_be_nxt        = m_be;
        m_wdata_nxt     = m_wdata;
        rdata_nxt       = rdata;
        rdata_valid_nxt = 1'b0;
        err_nxt         = 1'b0;

        case (state)
            S_IDLE: begin
                if (mem_rd && mem_wr) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_DONE;
                end else if (mem_rd) begin
                    if (addr[1:0] != 2'b00) begin
                        err_nxt   = 1'b1;
                        state_nxt = S_DONE;
                    end else begin
                        m_we_nxt   = 1'b0;
                        m_be_nxt   = 4'b1111;
                        m_addr_nxt = addr[ADDR_W+1:2];
                        m_req_nxt  = 1'b1;
                        cnt_nxt    = 8'd0;
                        state_nxt  = S_REQ;
                    end
                end else if (mem_wr) begin
                    if (w_h) begin
                        if (addr[1:0] != 2'b00) begin
                            err_nxt   = 1'b1;
                            state_nxt = S_DONE;
                        end else begin
                            m_we_nxt    = 1'b1;
                            m_be_nxt    = 4'b1111;
                            m_wdata_nxt = wdata;
                            m_addr_nxt  = addr[ADDR_W+1:2];
                            m_req_nxt   = 1'b1;
                            cnt_nxt     = 8'd0;
                            state_nxt   = S_REQ;
                        end
                    end else begin
                        if (addr[0]) begin
                            err_nxt   = 1'b1;
                            state_nxt = S_DONE;
                        end else begin
                            // Halfword is replicated to both lanes; byte enables pick the half.
                            m_we_nxt    = 1'b1;
                            m_be_nxt    = addr[1] ? 4'b1100 : 4'b0011;
                            m_wdata_nxt = {wdata[15:0], wdata[15:0]};
                            m_addr_nxt  = addr[ADDR_W+1:2];
                            m_req_nxt   = 1'b1;
                            cnt_nxt     = 8'd0;
                            state_nxt   = S_REQ;
                        end
                    end
                end
            end

            S_REQ: begin
                if (m_ack) begin
                    if (!m_we) begin
                        rdata_nxt       = m_rdata;
                        rdata_valid_nxt = 1'b1;
                    end
                    m_req_nxt = 1'b0;
                    state_nxt = S_DONE;
                end else if (cnt_inc == TO_CNT) begin
                    // Abort: a timed-out load still reports (zero) data so WB sees a defined value.
                    err_nxt = 1'b1;
                    if (!m_we) begin
                        rdata_nxt       = 32'd0;
                        rdata_valid_nxt = 1'b1;
                    end
                    cnt_nxt   = cnt_inc;
                    m_req_nxt = 1'b0;
                    state_nxt = S_DONE;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end

            S_DONE: begin
                // Same instruction is still presented here; ignore it and rearm.
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= 8'd0;
            m_req       <= 1'b0;
            m_we        <= 1'b0;
            m_addr      <= '0;
            m_be        <= 4'b0000;
            m_wdata     <= 32'd0;
            rdata       <= 32'd0;
            rdata_valid <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            m_req       <= m_req_nxt;
            m_we        <= m_we_nxt;
            m_addr      <= m_addr_nxt;
            m_be        <= m_be_nxt;
            m_wdata     <= m_wdata_nxt;
            rdata       <= rdata_nxt;
            rdata_valid <= rdata_valid_nxt;
            err         <= err_nxt;
        end
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

- MEM-stage responder for the `{MEM_RD, MEM_WR, w_h}` control bundle produced by the pipeline control decoder.
- Executes `lw`, `sw` and `sh` against a handshaked data memory, and holds the pipeline stalled while an access is in flight.
- Returns load data to the MEM/WB path, and flags misaligned, illegal or timed-out accesses.
- Sits between the EX/MEM pipe register and the external data memory.

## Interface
Parameters:
- `ADDR_W`, 10: word-address width of the data memory.
- `TIMEOUT`, 255: maximum REQ cycles without `m_ack` before the access is aborted (1..255).

Ports:
- `clk` in 1: single clock; all logic rising-edge.
- `rst_n` in 1: reset; asynchronous, active-low.
- `ctrl_mem` in 3: `{MEM_RD, MEM_WR, w_h}`.
  - `MEM_RD`/`MEM_WR`: 0 = active.
  - `w_h`: 1 = word, 0 = halfword.
- `addr` in 32: byte address (ALU result).
- `wdata` in 32: store data (rt).
- `stall` out 1: freeze IF..EX/MEM registers.
- `rdata` out 32: load result.
- `rdata_valid` out 1: one-cycle pulse when `rdata` updated.
- `err` out 1: one-cycle pulse on a misaligned, illegal or timed-out access.
- `m_req` out 1: memory request, level.
- `m_we` out 1: 1 = write.
- `m_addr` out ADDR_W: word address, `addr[ADDR_W+1:2]`.
- `m_be` out 4: byte enables, lane 0 = bits 7:0.
- `m_wdata` out 32: write data.
- `m_ack` in 1: memory completion, sampled in REQ only.
- `m_rdata` in 32: read data, valid with `m_ack`.

## Operation
States:
- IDLE: evaluate `ctrl_mem`.
  - `MEM_RD`=1, `MEM_WR`=1: no access; `stall`=0.
  - Read (`MEM_RD`=0, `MEM_WR`=1): word access; `w_h` is ignored.
    - `addr[1:0]` must be 00.
    - `m_be`=1111, `m_we`=0.
  - Write (`MEM_WR`=0, `MEM_RD`=1), word (`w_h`=1):
    - `addr[1:0]` must be 00.
    - `m_be`=1111, `m_wdata`=`wdata`.
  - Write, halfword (`w_h`=0):
    - `addr[0]` must be 0.
    - `m_be`=`addr[1]` ? 1100 : 0011.
    - `m_wdata`=`{wdata[15:0], wdata[15:0]}`.
  - Both `MEM_RD` and `MEM_WR` active: illegal; no memory access, `err` pulse, go to DONE.
  - Misaligned: no memory access, `err` pulse, go to DONE.
  - Legal access: register `m_addr`/`m_be`/`m_we`/`m_wdata`, clear the timeout counter, go to REQ.
- REQ:
  - `m_req`=1; `m_addr`/`m_be`/`m_we`/`m_wdata` held stable.
  - Counter increments each cycle without `m_ack`.
  - `m_ack`=1: capture `m_rdata` into `rdata` if a read; go to DONE.
  - Counter reaches `TIMEOUT` without ack: abort, `err` pulse, `rdata`=0 if a read; go to DONE.
- DONE:
  - `stall`=0; `rdata_valid`=1 for reads that completed or timed out.
  - Inputs ignored, because the same instruction is still presented; go to IDLE next cycle.
- `rdata` holds its value until the next read completes. Stores never modify `rdata`.
- `err` and `rdata_valid` are mutually exclusive, except on a read timeout, where both pulse in DONE.

## Timing
- `stall` is combinational: 1 when (IDLE and access requested, including illegal or misaligned) or REQ; 0 in DONE.
  - The pipe advances at the end of the DONE cycle.
- `m_req` is registered: it rises the cycle after IDLE accepts the access and falls the cycle after `m_ack` is sampled.
- Minimum legal access (ack in first REQ cycle):
  - cycle0 IDLE, `stall`=1;
  - cycle1 REQ, `stall`=1, `m_ack`=1;
  - cycle2 DONE, `stall`=0, `rdata_valid`=1.
  - Two stall cycles in total.
- Each ack wait adds one stall cycle. A timeout gives exactly `TIMEOUT` REQ cycles.
- Error path: cycle0 IDLE, `stall`=1; cycle1 DONE, `err`=1, `stall`=0. `m_req` never asserts.
- `m_ack` outside REQ is ignored.
- Reset (`rst_n`=0, any state, immediate and asynchronous):
  - state IDLE, counter 0.
  - All outputs 0, including `rdata`, `m_req`, `m_be`, `m_addr`, `m_wdata`.
  - `stall` follows the IDLE rule once `rst_n`=1.
  - An in-flight request is dropped; a late `m_ack` is ignored.

## Test plan
- lw `addr`=0x10, memory acks in the first REQ cycle with 0xDEADBEEF -> `m_addr`=4, `m_be`=1111, `stall` high 2 cycles, then `rdata`=0xDEADBEEF with a one-cycle `rdata_valid`.
- sh `addr`=0x22, `wdata`=0x1234ABCD, ack after 3 cycles -> `m_we`=1, `m_be`=1100, `m_wdata`=0xABCDABCD, `stall` high 4 cycles, `rdata` unchanged.
- sw `addr`=0x06; sh `addr`=0x03; `ctrl_mem`=001 -> each gives `err` pulse at cycle1, no `m_req`, exactly 1 stall cycle.
- lw with `m_ack` never asserted, `TIMEOUT`=4 -> 4 REQ cycles, then DONE with `err`=1, `rdata_valid`=1, `rdata`=0.
- `rst_n` pulled low during REQ, `m_ack` asserted afterwards -> `m_req`/`stall` drop immediately, no `rdata_valid`; the next lw completes normally.
- Back-to-back lw then sw with the same inputs held through DONE -> exactly two memory transactions, no duplicate request issued from DONE.
